dmem_access_arbiter: RTL
========================

// Module: dmem_access_arbiter
// PURPOSE
//  Arbitrates the single-port data memory between the pipeline MEM stage and the debug unit.
//  The debug unit requests a burst dump of N consecutive words. Dump reads are interleaved
//  with pipeline accesses under a starvation limit. Sits between the MemoryAccess stage and
//  DataMemory and drives the memory read_write/address/write-data mux.
// PARAMETERS
//  DATA_W     32  memory data width
//  ADDR_W     32  memory address width
//  CNT_W      10  width of dump word count
//  ADDR_STEP  1   address increment per dumped word (memory is word-indexed)
//  STARVE_MAX 4   max consecutive pipeline grants while a dump is pending (>=1)
// PORTS
//  clk        in  1       clock, all state updates on posedge
//  rst        in  1       asynchronous, active-low reset
//  pipe_rw    in  2       pipeline op: 00 none, 10 read, 01 write, 11 treated as request, forwarded as-is
//  pipe_addr  in  ADDR_W  pipeline address
//  pipe_wdata in  DATA_W  pipeline write data
//  pipe_rdata out DATA_W  = mem_rdata (combinational)
//  pipe_stall out 1       pipe_rw!=00 and pipeline not granted this cycle (combinational)
//  dbg_start  in  1       start dump, sampled only in IDLE
//  dbg_abort  in  1       terminate dump
//  dbg_base   in  ADDR_W  first dump address, sampled with dbg_start
//  dbg_count  in  CNT_W   words to dump, sampled with dbg_start
//  dbg_busy   out 1       1 in DUMP or DONE (registered state decode)
//  dbg_valid  out 1       registered: dbg_data/dbg_addr hold a dumped word this cycle
//  dbg_data   out DATA_W  registered captured word
//  dbg_addr   out ADDR_W  registered address of captured word
//  dbg_done   out 1       registered one-cycle pulse, dump finished or aborted
//  mem_rw     out 2       to DataMemory read_write
//  mem_addr   out ADDR_W  to DataMemory address
//  mem_wdata  out DATA_W  to DataMemory write data
//  mem_rdata  in  DATA_W  from DataMemory (combinational read)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; dbg_valid, dbg_done, dbg_data, dbg_addr, counters = 0.
//   Memory mux follows the pipeline, so mem_rw=pipe_rw and pipe_stall=0.
//  States: IDLE, DUMP, DONE. cur_addr, remain, starve are registered.
//  IDLE: pipeline always granted.
//   dbg_start: cur_addr<=dbg_base, remain<=dbg_count, starve<=0.
//   Next state is DUMP if dbg_count!=0, else DONE.
//  DUMP: if dbg_abort -> DONE; no debug read issued; pipeline granted.
//   Else if pipe_rw!=00 and starve<STARVE_MAX: grant pipeline, starve++.
//   Else debug read issued:
//    - mem_rw=10, mem_addr=cur_addr, mem_wdata=0; pipe_stall=(pipe_rw!=00).
//    - On the clock edge: dbg_data<=mem_rdata, dbg_addr<=cur_addr, dbg_valid<=1, starve<=0.
//    - cur_addr<=cur_addr+ADDR_STEP, mod 2^ADDR_W (wraps); remain--.
//    - If remain becomes 0, next state is DONE.
//  dbg_valid is 1 for exactly one cycle per issued read, i.e. the cycle after issue.
//  DONE: one cycle. dbg_done=1, pipeline granted, then IDLE. The last dbg_valid coincides with dbg_done.
//  When the pipeline is granted: mem_rw/addr/wdata = pipe_*.
//  Ignored inputs: dbg_start outside IDLE; dbg_abort outside DUMP.
//  Reset mid-dump: immediate return to IDLE with no dbg_done pulse.
// TESTING
//  1. Hold rst=0, then release; pipe_rw=01, addr=5 -> mem_rw=01, mem_addr=5, stall=0, dbg_valid=0.
//  2. Idle pipe; start base=0x10 count=3 at edge0.
//     -> dbg_valid on cycles 2,3,4 with addr 0x10,0x11,0x12 and data M[addr].
//     -> dbg_done=1 in cycle 4; IDLE in cycle 5.
//  3. pipe_rw=10 constant during a dump of 2 words -> per 5 cycles: 4 grants then 1 stall cycle
//     with mem_rw=10 and mem_addr=debug address; done after 10 dump cycles.
//  4. dbg_count=0 -> dbg_done pulse in cycle after start; dbg_valid never asserted.
//  5. base=0xFFFFFFFF count=2 -> dbg_addr 0xFFFFFFFF then 0x00000000.
//     Abort after the first word of count=8 -> dbg_done next cycle, no further reads.
//  6. rst=0 mid-dump -> immediately IDLE, all dbg_* outputs 0; a new start after release works.

Source files
------------

// File: rtl/dmem_access_arbiter_if.sv
// Bus bundle around the data-memory arbiter: pipeline MEM-stage port, debug dump port
// and the DataMemory mux port. The arbiter sits on the slave side.
interface dmem_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 10
);
  // Pipeline MEM stage
  logic [1:0]        pipe_rw;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_wdata;
  logic [DATA_W-1:0] pipe_rdata;
  logic              pipe_stall;

  // Debug dump port
  logic              dbg_start;
  logic              dbg_abort;
  logic [ADDR_W-1:0] dbg_base;
  logic [CNT_W-1:0]  dbg_count;
  logic              dbg_busy;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_done;

  // DataMemory port
  logic [1:0]        mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  pipe_rw, pipe_addr, pipe_wdata,
    output pipe_rdata, pipe_stall,
    input  dbg_start, dbg_abort, dbg_base, dbg_count,
    output dbg_busy, dbg_valid, dbg_data, dbg_addr, dbg_done,
    output mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output pipe_rw, pipe_addr, pipe_wdata,
    input  pipe_rdata, pipe_stall,
    output dbg_start, dbg_abort, dbg_base, dbg_count,
    input  dbg_busy, dbg_valid, dbg_data, dbg_addr, dbg_done,
    input  mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Shares the single-port data memory between the pipeline and a debug burst dump.
// Dump reads are interleaved with pipeline traffic, bounded by a starvation limit.
module dmem_access_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 10,
  parameter int ADDR_STEP  = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                   clk,
  input logic                   rst,
  dmem_access_arbiter_if.slave  bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                dbg_valid_q;
  logic [DATA_W-1:0]   dbg_data_q;
  logic [ADDR_W-1:0]   dbg_addr_q;
  logic                dbg_done_q;

  logic pipe_req;
  logic dbg_issue;

  assign pipe_req = (bus.pipe_rw != 2'b00);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    starve_d   = starve_q;
    dbg_issue  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.dbg_start) begin
          cur_addr_d = bus.dbg_base;
          remain_d   = bus.dbg_count;
          starve_d   = '0;
          state_d    = (bus.dbg_count != '0) ? DUMP : DONE;
        end
      end
      DUMP: begin
        if (bus.dbg_abort) begin
          state_d = DONE;
        end else if (pipe_req && (starve_q < STARVE_W'(STARVE_MAX))) begin
          starve_d = starve_q + STARVE_W'(1);
        end else begin
          // Debug read wins this cycle; the pipeline (if requesting) is stalled.
          dbg_issue  = 1'b1;
          starve_d   = '0;
          cur_addr_d = cur_addr_q + ADDR_W'(ADDR_STEP);
          remain_d   = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rw     = bus.pipe_rw;
    bus.mem_addr   = bus.pipe_addr;
    bus.mem_wdata  = bus.pipe_wdata;
    bus.pipe_stall = 1'b0;
    if (dbg_issue) begin
      bus.mem_rw     = 2'b10;
      bus.mem_addr   = cur_addr_q;
      bus.mem_wdata  = '0;
      bus.pipe_stall = pipe_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      starve_q    <= '0;
      dbg_valid_q <= 1'b0;
      dbg_data_q  <= '0;
      dbg_addr_q  <= '0;
      dbg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      starve_q    <= starve_d;
      dbg_valid_q <= dbg_issue;
      dbg_done_q  <= (state_d == DONE);
      if (dbg_issue) begin
        dbg_data_q <= bus.mem_rdata;
        dbg_addr_q <= cur_addr_q;
      end
    end
  end

  assign bus.pipe_rdata = bus.mem_rdata;
  assign bus.dbg_busy   = (state_q != IDLE);
  assign bus.dbg_valid  = dbg_valid_q;
  assign bus.dbg_data   = dbg_data_q;
  assign bus.dbg_addr   = dbg_addr_q;
  assign bus.dbg_done   = dbg_done_q;

endmodule
